// File: rtl/sb_commit_ctrl.sv
// Scoreboard sequencing controller: in-order trans_id allocation, out-of-order writeback, in-order commit.
// Optional feature: define SB_COMMIT_BYPASS_EN to forward a same-cycle head writeback straight to commit.
module sb_commit_ctrl #(
  parameter int NR_SB_ENTRIES = 4,
  parameter int TRANS_ID_BITS = $clog2(NR_SB_ENTRIES),
  parameter int NR_WB_PORTS   = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic                                 issue_valid_i,
  output logic                                 issue_ready_o,
  output logic [TRANS_ID_BITS-1:0]             issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]               wb_valid_i,
  input  logic [NR_WB_PORTS*TRANS_ID_BITS-1:0] wb_trans_id_i,
  input  logic [NR_WB_PORTS*64-1:0]            wb_result_i,
  input  logic [NR_WB_PORTS-1:0]               wb_ex_valid_i,
  output logic                                 commit_valid_o,
  input  logic                                 commit_ack_i,
  output logic [TRANS_ID_BITS-1:0]             commit_trans_id_o,
  output logic [63:0]                          commit_result_o,
  output logic                                 commit_ex_o,
  output logic [TRANS_ID_BITS:0]               count_o
);

  localparam logic [TRANS_ID_BITS:0] SB_DEPTH = (TRANS_ID_BITS+1)'(NR_SB_ENTRIES);

  typedef enum logic [1:0] {
    ENTRY_FREE,
    ENTRY_ISSUED,
    ENTRY_DONE
  } entry_state_e;

  entry_state_e             state_q  [NR_SB_ENTRIES];
  entry_state_e             state_d  [NR_SB_ENTRIES];
  logic [63:0]              result_q [NR_SB_ENTRIES];
  logic [63:0]              result_d [NR_SB_ENTRIES];
  logic                     ex_q     [NR_SB_ENTRIES];
  logic                     ex_d     [NR_SB_ENTRIES];
  logic [TRANS_ID_BITS-1:0] head_q, head_d, tail_q, tail_d;
  logic [TRANS_ID_BITS:0]   count_q, count_d;

  logic                     wb_hit [NR_SB_ENTRIES];
  logic [63:0]              wb_res [NR_SB_ENTRIES];
  logic                     wb_ex  [NR_SB_ENTRIES];
  logic                     issue_fire, commit_fire;

  // Per entry, pick the writeback port that targets it; scanning high to low lets the lowest port win.
  always_comb begin
    for (int e = 0; e < NR_SB_ENTRIES; e++) begin
      wb_hit[e] = 1'b0;
      wb_res[e] = '0;
      wb_ex[e]  = 1'b0;
      for (int p = NR_WB_PORTS - 1; p >= 0; p--) begin
        if (wb_valid_i[p] &&
            wb_trans_id_i[p*TRANS_ID_BITS +: TRANS_ID_BITS] == TRANS_ID_BITS'(e)) begin
          wb_hit[e] = 1'b1;
          wb_res[e] = wb_result_i[p*64 +: 64];
          wb_ex[e]  = wb_ex_valid_i[p];
        end
      end
    end
  end

  always_comb begin
    commit_valid_o  = (state_q[head_q] == ENTRY_DONE);
    commit_result_o = result_q[head_q];
    commit_ex_o     = ex_q[head_q];
`ifdef SB_COMMIT_BYPASS_EN
    if (state_q[head_q] == ENTRY_ISSUED && wb_hit[head_q]) begin
      commit_valid_o  = 1'b1;
      commit_result_o = wb_res[head_q];
      commit_ex_o     = wb_ex[head_q];
    end
`endif
  end

  assign issue_ready_o     = (count_q < SB_DEPTH);
  assign issue_trans_id_o  = tail_q;
  assign commit_trans_id_o = head_q;
  assign count_o           = count_q;
  assign issue_fire        = issue_valid_i && issue_ready_o;
  assign commit_fire       = commit_valid_o && commit_ack_i;

  // Commit is applied after writeback so a bypassed, acked head entry lands directly in FREE.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    ex_d     = ex_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    if (flush_i) begin
      for (int e = 0; e < NR_SB_ENTRIES; e++) begin
        state_d[e] = ENTRY_FREE;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int e = 0; e < NR_SB_ENTRIES; e++) begin
        if (state_q[e] == ENTRY_ISSUED && wb_hit[e]) begin
          state_d[e]  = ENTRY_DONE;
          result_d[e] = wb_res[e];
          ex_d[e]     = wb_ex[e];
        end
      end
      if (issue_fire) begin
        state_d[tail_q] = ENTRY_ISSUED;
        tail_d          = tail_q + 1'b1;
      end
      if (commit_fire) begin
        state_d[head_q] = ENTRY_FREE;
        head_d          = head_q + 1'b1;
      end
      case ({issue_fire, commit_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int e = 0; e < NR_SB_ENTRIES; e++) begin
        state_q[e]  <= ENTRY_FREE;
        result_q[e] <= '0;
        ex_q[e]     <= 1'b0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ex_q     <= ex_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_sb_commit_ctrl.sv
// Self-checking bench for sb_commit_ctrl: directed scenarios plus randomized traffic against a queue model.
// Build with SB_COMMIT_BYPASS_EN defined to exercise the bypass expectations.
module tb_sb_commit_ctrl;

  localparam int N  = 4;
  localparam int TB = 2;
  localparam int P  = 4;
`ifdef SB_COMMIT_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush, issue_valid, commit_ack;
  logic [P-1:0]    wb_valid, wb_ex;
  logic [P*TB-1:0] wb_id;
  logic [P*64-1:0] wb_res;
  logic            issue_ready, commit_valid, commit_ex;
  logic [TB-1:0]   issue_id, commit_id;
  logic [63:0]     commit_result;
  logic [TB:0]     count;

  int checks = 0;
  int failures = 0;

  sb_commit_ctrl #(.NR_SB_ENTRIES(N), .NR_WB_PORTS(P)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_trans_id_o(issue_id),
    .wb_valid_i(wb_valid), .wb_trans_id_i(wb_id), .wb_result_i(wb_res), .wb_ex_valid_i(wb_ex),
    .commit_valid_o(commit_valid), .commit_ack_i(commit_ack), .commit_trans_id_o(commit_id),
    .commit_result_o(commit_result), .commit_ex_o(commit_ex), .count_o(count)
  );

  always #5 clk = ~clk;

  // Reference model: outstanding instructions in program order.
  typedef struct {
    int          id;
    bit          done;
    logic [63:0] res;
    bit          ex;
  } ent_t;

  ent_t mq[$];
  int   m_tail;

  function automatic int find_pos(int id);
    for (int i = 0; i < mq.size(); i++) if (mq[i].id == id) return i;
    return -1;
  endfunction

  function automatic void model_commit(output bit cv, output logic [63:0] r, output bit ex);
    bit found;
    cv = 1'b0; r = '0; ex = 1'b0; found = 1'b0;
    if (mq.size() > 0) begin
      if (mq[0].done) begin
        cv = 1'b1; r = mq[0].res; ex = mq[0].ex;
      end else if (BYPASS) begin
        for (int p = 0; p < P; p++) begin
          if (!found && wb_valid[p] && int'(wb_id[p*TB +: TB]) == mq[0].id) begin
            found = 1'b1; cv = 1'b1; r = wb_res[p*64 +: 64]; ex = wb_ex[p];
          end
        end
      end
    end
  endfunction

  function automatic void model_update();
    bit          cv, ex, ready;
    logic [63:0] r;
    int          pos;
    if (flush) begin
      mq.delete();
      m_tail = 0;
      return;
    end
    ready = (mq.size() < N);
    model_commit(cv, r, ex);
    for (int p = 0; p < P; p++) begin
      if (wb_valid[p]) begin
        pos = find_pos(int'(wb_id[p*TB +: TB]));
        if (pos >= 0 && !mq[pos].done) begin
          mq[pos].done = 1'b1;
          mq[pos].res  = wb_res[p*64 +: 64];
          mq[pos].ex   = wb_ex[p];
        end
      end
    end
    if (cv && commit_ack) void'(mq.pop_front());
    if (issue_valid && ready) begin
      mq.push_back('{id: m_tail, done: 1'b0, res: '0, ex: 1'b0});
      m_tail = (m_tail + 1) % N;
    end
  endfunction

  task automatic clear_inputs();
    flush = 0; issue_valid = 0; commit_ack = 0;
    wb_valid = '0; wb_ex = '0; wb_id = '0; wb_res = '0;
  endtask

  task automatic wb_set(input int port, input int id, input logic [63:0] res, input bit ex);
    wb_valid[port]          = 1'b1;
    wb_id[port*TB +: TB]    = TB'(id);
    wb_res[port*64 +: 64]   = res;
    wb_ex[port]             = ex;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    mq.delete();
    m_tail = 0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", issue_ready); end
    checks++; if (issue_id !== 2'd0) begin failures++; $display("[TB] FAIL reset_issue_id got=%0d exp=0", issue_id); end
    checks++; if (commit_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_commit_valid got=%b exp=0", commit_valid); end
    checks++; if (commit_id !== 2'd0) begin failures++; $display("[TB] FAIL reset_commit_id got=%0d exp=0", commit_id); end
    checks++; if (commit_result !== 64'd0) begin failures++; $display("[TB] FAIL reset_commit_result got=%h exp=0", commit_result); end
    checks++; if (commit_ex !== 1'b0) begin failures++; $display("[TB] FAIL reset_commit_ex got=%b exp=0", commit_ex); end
    checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
    do_reset();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < N; i++) begin
      issue_valid = 1'b1;
      #1;
      checks++; if (issue_id !== TB'(i)) begin failures++; $display("[TB] FAIL b2b_issue_id got=%0d exp=%0d", issue_id, i); end
      checks++; if (issue_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready got=%b exp=1", issue_ready); end
      tick();
    end
    #1;
    checks++; if (count !== 3'd4) begin failures++; $display("[TB] FAIL b2b_count got=%0d exp=4", count); end
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("[TB] FAIL b2b_full_ready got=%b exp=0", issue_ready); end
    clear_inputs();
  endtask

  task automatic test_out_of_order_wb();
    do_reset();
    issue_valid = 1'b1; tick(); tick(); issue_valid = 1'b0;
    wb_set(2, 1, 64'hBEEF, 1'b0);
    #1;
    checks++; if (commit_valid !== 1'b0) begin failures++; $display("[TB] FAIL ooo_wb1_valid got=%b exp=0", commit_valid); end
    tick(); clear_inputs();
    #1;
    checks++; if (commit_valid !== 1'b0) begin failures++; $display("[TB] FAIL ooo_after_wb1_valid got=%b exp=0", commit_valid); end
    wb_set(0, 0, 64'h1234, 1'b0);
    #1;
    checks++; if (commit_valid !== BYPASS) begin failures++; $display("[TB] FAIL ooo_wb0_same_cycle_valid got=%b exp=%b", commit_valid, BYPASS); end
    tick(); clear_inputs();
    #1;
    checks++; if (commit_valid !== 1'b1 || commit_result !== 64'h1234 || commit_id !== 2'd0) begin
      failures++; $display("[TB] FAIL ooo_commit0 got v=%b r=%h id=%0d exp v=1 r=1234 id=0", commit_valid, commit_result, commit_id); end
    commit_ack = 1'b1; tick();
    #1;
    checks++; if (commit_valid !== 1'b1 || commit_result !== 64'hBEEF || commit_id !== 2'd1) begin
      failures++; $display("[TB] FAIL ooo_commit1 got v=%b r=%h id=%0d exp v=1 r=beef id=1", commit_valid, commit_result, commit_id); end
    tick(); commit_ack = 1'b0;
    #1;
    checks++; if (commit_valid !== 1'b0 || count !== 3'd0) begin
      failures++; $display("[TB] FAIL ooo_drained got v=%b cnt=%0d exp v=0 cnt=0", commit_valid, count); end
  endtask

  task automatic test_port_priority();
    do_reset();
    issue_valid = 1'b1; tick(); issue_valid = 1'b0;
    wb_set(1, 0, 64'hAA, 1'b0);
    wb_set(3, 0, 64'hBB, 1'b1);
    tick(); clear_inputs();
    #1;
    checks++; if (commit_valid !== 1'b1 || commit_result !== 64'hAA || commit_ex !== 1'b0) begin
      failures++; $display("[TB] FAIL prio_winner got v=%b r=%h ex=%b exp v=1 r=aa ex=0", commit_valid, commit_result, commit_ex); end
    wb_set(0, 0, 64'hCC, 1'b1);
    tick(); clear_inputs();
    #1;
    checks++; if (commit_result !== 64'hAA || commit_ex !== 1'b0) begin
      failures++; $display("[TB] FAIL prio_done_overwrite got r=%h ex=%b exp r=aa ex=0", commit_result, commit_ex); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    issue_valid = 1'b1;
    for (int i = 0; i < N; i++) tick();
    issue_valid = 1'b0;
    wb_set(0, 0, 64'h11, 1'b0);
    tick(); clear_inputs();
    issue_valid = 1'b1; commit_ack = 1'b1;
    #1;
    checks++; if (commit_valid !== 1'b1 || issue_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL full_pop_cycle got v=%b rdy=%b exp v=1 rdy=0", commit_valid, issue_ready); end
    tick(); commit_ack = 1'b0;
    #1;
    checks++; if (count !== 3'd3 || issue_id !== 2'd0 || issue_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL full_after_pop got cnt=%0d id=%0d rdy=%b exp cnt=3 id=0 rdy=1", count, issue_id, issue_ready); end
    tick(); issue_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd4 || commit_id !== 2'd1) begin
      failures++; $display("[TB] FAIL full_wrap_issue got cnt=%0d head=%0d exp cnt=4 head=1", count, commit_id); end
  endtask

  task automatic test_flush();
    do_reset();
    issue_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    issue_valid = 1'b0;
    wb_set(0, 0, 64'h77, 1'b0);
    tick(); clear_inputs();
    flush = 1'b1; issue_valid = 1'b1; commit_ack = 1'b1;
    tick(); clear_inputs();
    #1;
    checks++; if (count !== 3'd0 || commit_valid !== 1'b0 || issue_id !== 2'd0 || commit_id !== 2'd0 || issue_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL flush_state got cnt=%0d v=%b tail=%0d head=%0d rdy=%b exp 0/0/0/0/1",
                           count, commit_valid, issue_id, commit_id, issue_ready); end
  endtask

  task automatic test_bypass();
    do_reset();
    issue_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    issue_valid = 1'b0;
    wb_set(0, 0, 64'h1, 1'b0); wb_set(1, 1, 64'h2, 1'b0);
    tick(); clear_inputs();
    commit_ack = 1'b1; tick(); tick(); commit_ack = 1'b0;
    wb_set(0, 2, 64'h55, 1'b0); commit_ack = 1'b1;
    #1;
    checks++; if (commit_valid !== BYPASS || commit_id !== 2'd2) begin
      failures++; $display("[TB] FAIL bypass_same_cycle got v=%b head=%0d exp v=%b head=2", commit_valid, commit_id, BYPASS); end
    if (BYPASS) begin
      checks++; if (commit_result !== 64'h55) begin failures++; $display("[TB] FAIL bypass_result got=%h exp=55", commit_result); end
    end
    tick(); clear_inputs();
    #1;
    if (BYPASS) begin
      checks++; if (commit_id !== 2'd3 || count !== 3'd0 || commit_valid !== 1'b0) begin
        failures++; $display("[TB] FAIL bypass_next got head=%0d cnt=%0d v=%b exp head=3 cnt=0 v=0", commit_id, count, commit_valid); end
    end else begin
      checks++; if (commit_valid !== 1'b1 || commit_result !== 64'h55 || commit_id !== 2'd2) begin
        failures++; $display("[TB] FAIL nobypass_next got v=%b r=%h head=%0d exp v=1 r=55 head=2", commit_valid, commit_result, commit_id); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    issue_valid = 1'b1; tick(); tick(); issue_valid = 1'b0;
    wb_set(0, 0, 64'h99, 1'b1);
    tick(); clear_inputs();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || commit_valid !== 1'b0 || commit_result !== 64'd0 || commit_ex !== 1'b0 || issue_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL async_reset got cnt=%0d v=%b r=%h ex=%b rdy=%b exp 0/0/0/0/1",
                           count, commit_valid, commit_result, commit_ex, issue_ready); end
    do_reset();
  endtask

  task automatic test_random();
    bit          cv, ex;
    logic [63:0] r;
    int          id, exp_head;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      clear_inputs();
      issue_valid = ($urandom_range(0, 2) != 0);
      commit_ack  = ($urandom_range(0, 1) == 1);
      flush       = ($urandom_range(0, 39) == 0);
      for (int p = 0; p < P; p++) begin
        if ($urandom_range(0, 9) < 4) begin
          if (mq.size() > 0 && $urandom_range(0, 3) != 0) id = mq[$urandom_range(0, mq.size() - 1)].id;
          else id = $urandom_range(0, N - 1);
          wb_set(p, id, {$urandom, $urandom}, $urandom_range(0, 1) == 1);
        end
      end
      #1;
      model_commit(cv, r, ex);
      exp_head = (mq.size() > 0) ? mq[0].id : m_tail;
      checks++; if (count !== (TB+1)'(mq.size())) begin failures++; $display("[TB] FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, count, mq.size()); end
      checks++; if (issue_ready !== (mq.size() < N)) begin failures++; $display("[TB] FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, issue_ready, mq.size() < N); end
      checks++; if (issue_id !== TB'(m_tail)) begin failures++; $display("[TB] FAIL rand_issue_id cyc=%0d got=%0d exp=%0d", cyc, issue_id, m_tail); end
      checks++; if (commit_id !== TB'(exp_head)) begin failures++; $display("[TB] FAIL rand_commit_id cyc=%0d got=%0d exp=%0d", cyc, commit_id, exp_head); end
      checks++; if (commit_valid !== cv) begin failures++; $display("[TB] FAIL rand_commit_valid cyc=%0d got=%b exp=%b", cyc, commit_valid, cv); end
      if (cv) begin
        checks++; if (commit_result !== r || commit_ex !== ex) begin
          failures++; $display("[TB] FAIL rand_commit_data cyc=%0d got r=%h ex=%b exp r=%h ex=%b", cyc, commit_result, commit_ex, r, ex); end
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b1;
    clear_inputs();
    mq.delete();
    m_tail = 0;
    test_reset();
    test_back_to_back();
    test_out_of_order_wb();
    test_port_priority();
    test_full_wrap();
    test_flush();
    test_bypass();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sb_commit_ctrl.md
Name: sb_commit_ctrl

Overview:
- Scoreboard sequencing controller for the issue/writeback/commit path.
- Allocates transaction IDs (trans_id) to issued instructions in program order.
- Collects results from NR_WB_PORTS writeback ports in any order and presents them to the commit stage strictly in order.
- Sits between the issue stage, the functional-unit writeback buses and the commit stage; owns the trans_id namespace.

Parameters:
- NR_SB_ENTRIES, 4: scoreboard depth; power of two, >= 2.
- TRANS_ID_BITS, $clog2(NR_SB_ENTRIES): trans_id width.
- NR_WB_PORTS, 4: number of writeback ports.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  discard all entries (mispredict/exception).
- issue_valid_i  in  1  issue stage requests an entry.
- issue_ready_o  out  1  entry available.
- issue_trans_id_o  out  TRANS_ID_BITS  ID that the current issue will receive (tail pointer).
- wb_valid_i  in  NR_WB_PORTS  per-port writeback strobe.
- wb_trans_id_i  in  NR_WB_PORTS*TRANS_ID_BITS  per-port target ID; port p in slice [p*TRANS_ID_BITS +: TRANS_ID_BITS].
- wb_result_i  in  NR_WB_PORTS*64  per-port result.
- wb_ex_valid_i  in  NR_WB_PORTS  per-port exception flag.
- commit_valid_o  out  1  head entry finished.
- commit_ack_i  in  1  commit stage consumes head.
- commit_trans_id_o  out  TRANS_ID_BITS  head pointer.
- commit_result_o  out  64  head result.
- commit_ex_o  out  1  head exception flag.
- count_o  out  TRANS_ID_BITS+1  occupied entries.

Behaviour:
- Reset values: issue_ready_o=1, issue_trans_id_o=0, commit_valid_o=0, commit_trans_id_o=0, commit_result_o=0, commit_ex_o=0, count_o=0.
- Reset (async, rst_ni=0) clears all entry states to FREE, result and ex storage to 0, head=tail=0, count=0, at any point mid-operation.
- Per-entry state: FREE -> ISSUED (issue handshake at tail) -> DONE (writeback) -> FREE (commit handshake at head).
- Issue: fires when issue_valid_i && issue_ready_o; tail increments mod NR_SB_ENTRIES.
- issue_ready_o = (count < NR_SB_ENTRIES), taken from the registered count only. No full-bypass: a commit in the same cycle does not raise ready.
- Writeback: port p with wb_valid_i[p] and target entry ISSUED stores the result and ex flag; entry becomes DONE next cycle.
- A writeback to a FREE or DONE entry is ignored; no state change, no overwrite.
- Several ports targeting the same ID in one cycle: lowest port index wins; the others are ignored.
- Commit: commit_valid_o = head entry DONE (registered state; first visible the cycle after writeback). commit_* outputs always reflect the head entry.
- commit_valid_o && commit_ack_i frees the head; head increments mod N. commit_ack_i while commit_valid_o=0 is ignored.
- Count: +1 on issue, -1 on commit, unchanged on both in the same cycle.
- Wrap-around: pointers are TRANS_ID_BITS wide and wrap naturally. Full is distinguished from empty by count only.
- Flush: in the next cycle all entries are FREE, head=tail=0, count=0. Flush overrides any issue, writeback or commit in the same cycle; the issue handshake is not counted and commit is not consumed.

Optional Feature:
- Macro SB_COMMIT_BYPASS_EN.
- Defined: if the head entry is ISSUED and a winning writeback targets it this cycle, commit_valid_o asserts combinationally this cycle, with commit_result_o/commit_ex_o driven from that port. If acked, the entry goes directly to FREE.
- Undefined: registered-only behaviour as above; writeback-to-commit latency is exactly 1 cycle.

Test Plan:
- Reset then issue 4 back-to-back -> IDs 0,1,2,3; count_o=4; issue_ready_o=0 in the cycle after the 4th issue.
- Issue IDs 0,1; writeback ID1=0xBEEF on port 2, then ID0=0x1234 on port 0 -> commit_valid_o rises only after ID0 is written. Commits occur as 0x1234 then 0xBEEF, in order.
- Ports 1 and 3 both write ID0 with 0xAA and 0xBB in the same cycle -> commit_result_o=0xAA. A later port-0 write of 0xCC to ID0 (now DONE) is ignored.
- Full (count=4) with head DONE, issue_valid_i=1 and commit_ack_i=1 in the same cycle -> commit pops, issue not accepted, count_o=3. Next issue receives ID0 (wrap).
- Three entries issued, one DONE, flush_i=1 together with issue_valid_i and commit_ack_i -> next cycle count_o=0, commit_valid_o=0, issue_trans_id_o=0.
- With SB_COMMIT_BYPASS_EN: head ID2 ISSUED, wb port 0 writes ID2=0x55 with ack=1 -> commit_valid_o=1 and commit_result_o=0x55 in the same cycle; next cycle head=3. Without the macro -> commit_valid_o rises one cycle later.
